sd_crc_serial: RTL and testbench



---
 rtl/sd_crc_pkg.sv | 49 ++++
 rtl/sd_crc_serial.sv | 67 ++++++
 tb/tb_sd_crc_serial.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_crc_pkg.sv
// -----------------------------------------------------------------------------
// sd_crc_pkg
//   Shared constants and the single-bit CRC update step for the SD bus
//   CRC generators/checkers (CRC7 on CMD, CRC16-CCITT per DAT lane).
//
//   crc_step() works on a register held in the low `width` bits of a
//   CRC_MAX_WIDTH-bit vector. This lets a single pure function serve every
//   legal CRC width (2..32). The RTL and the testbench reference model both
//   call it.
// -----------------------------------------------------------------------------
package sd_crc_pkg;

  localparam int unsigned CRC_MAX_WIDTH = 32;

  // CMD line: x^7 + x^3 + 1
  localparam int unsigned SD_CRC7_WIDTH  = 7;
  localparam logic [6:0]  SD_CRC7_POLY   = 7'h09;

  // DAT lines: x^16 + x^12 + x^5 + 1 (CCITT)
  localparam int unsigned SD_CRC16_WIDTH = 16;
  localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

  localparam int unsigned SD_DAT_LANES   = 4;

  // Mask that keeps the low `width` bits. A shift by 32 would overflow the
  // 32-bit literal, so the full-width case gets its own branch.
  function automatic logic [CRC_MAX_WIDTH-1:0] crc_mask(input int unsigned width);
    crc_mask = (width >= CRC_MAX_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
  endfunction

  // One MSB-first update step. The feedback bit is the incoming message bit
  // XOR the current register MSB. The register shifts left. On feedback the
  // polynomial (with its implicit x^width term dropped) is folded in.
  function automatic logic [CRC_MAX_WIDTH-1:0] crc_step(
    input logic [CRC_MAX_WIDTH-1:0] s,
    input logic                     d,
    input logic [CRC_MAX_WIDTH-1:0] poly,
    input int unsigned              width
  );
    logic [CRC_MAX_WIDTH-1:0] msb_vec;
    logic                     fb;
    logic [CRC_MAX_WIDTH-1:0] shifted;
    msb_vec  = s >> (width - 1);
    fb       = d ^ msb_vec[0];
    shifted  = s << 1;
    crc_step = (shifted ^ (fb ? poly : '0)) & crc_mask(width);
  endfunction

endpackage

// File: rtl/sd_crc_serial.sv
// -----------------------------------------------------------------------------
// sd_crc_serial
//   Bit-serial, MSB-first CRC generator/checker for the SD bus. Use one
//   instance with the CRC7 parameters on CMD, and one instance per DAT lane
//   with the CRC16 parameters. The register starts at zero. There is no
//   reflection and no final XOR.
//
//   Generate: feed the message, then read `crc` (or shift it out MSB-first
//             while feeding the same bits back in, which leaves crc == 0).
//   Check:    feed the message followed by the received CRC bits. The frame
//             is error-free if and only if crc == 0 afterwards.
//
//   Parameters
//     WIDTH : CRC register width, legal range 2..32
//     POLY  : generator polynomial without the implicit x^WIDTH term
//
//   Ports
//     clk   : clock; all state changes on the rising edge
//     rst   : synchronous, active-high. With en=1 in the same cycle, the
//             bit on `data` is absorbed into a freshly cleared register.
//     en    : bit strobe; absorb `data` this cycle
//     data  : next message bit, frame MSB first
//     crc   : current remainder, driven straight from the state register
// -----------------------------------------------------------------------------
module sd_crc_serial
  import sd_crc_pkg::*;
#(
  parameter int unsigned       WIDTH = SD_CRC7_WIDTH,
  parameter logic [WIDTH-1:0]  POLY  = SD_CRC7_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data,
  output logic [WIDTH-1:0] crc
);

  // NOTE: the declaration initializer gives the same zero at power-on in
  // simulation as a reset does. Synthesis tools that support register init
  // values map it onto the flops.
  logic [WIDTH-1:0] r = '0;

  logic [CRC_MAX_WIDTH-1:0] seed;
  logic [WIDTH-1:0]         step;

  // A reset in the same cycle as a bit strobe seeds the update from zero.
  // This lets the start bit be issued together with the reset.
  always_comb begin
    seed = rst ? '0 : CRC_MAX_WIDTH'(r);
    step = WIDTH'(crc_step(seed, data, CRC_MAX_WIDTH'(POLY), WIDTH));
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // samples values from before the edge.
  // `data` is only looked at when en=1, so an undefined bit during idle gaps
  // cannot reach the register.
  always_ff @(posedge clk) begin
    if (en) begin
      r <= step;
    end else if (rst) begin
      r <= '0;
    end
  end

  assign crc = r;

endmodule

// File: tb/tb_sd_crc_serial.sv
// -----------------------------------------------------------------------------
// tb_sd_crc_serial
//   Directed bench for sd_crc_serial. One CRC7 instance (CMD) and one CRC16
//   instance (DAT lane) are driven independently. Inputs change on the
//   falling edge. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sd_crc_serial;
  import sd_crc_pkg::*;

  localparam logic [39:0] CMD0  = 40'h40_0000_0000;
  localparam logic [39:0] CMD8  = 40'h48_0000_01AA;
  localparam logic [39:0] CMD17 = 40'h51_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst7  = 1'b0, en7  = 1'b0, data7  = 1'b0;
  logic        rst16 = 1'b0, en16 = 1'b0, data16 = 1'b0;
  logic [6:0]  crc7;
  logic [15:0] crc16;

  int vectors     = 0;
  int miscompares = 0;

  sd_crc_serial #(.WIDTH(SD_CRC7_WIDTH), .POLY(SD_CRC7_POLY)) u_crc7 (
    .clk (clk), .rst (rst7), .en (en7), .data (data7), .crc (crc7)
  );

  sd_crc_serial #(.WIDTH(SD_CRC16_WIDTH), .POLY(SD_CRC16_POLY)) u_crc16 (
    .clk (clk), .rst (rst16), .en (en16), .data (data16), .crc (crc16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- CRC7 drivers ---------------------------------------------------------
  task automatic bit7(input logic d, input logic r);
    @(negedge clk);
    rst7 = r; en7 = 1'b1; data7 = d;
    @(posedge clk);
    #1;
    rst7 = 1'b0; en7 = 1'b0; data7 = 1'bx;
  endtask

  task automatic idle7(input logic r, input logic d);
    @(negedge clk);
    rst7 = r; en7 = 1'b0; data7 = d;
    @(posedge clk);
    #1;
    rst7 = 1'b0; data7 = 1'bx;
  endtask

  task automatic frame7(input logic [63:0] v, input int n, input logic first_rst);
    for (int i = n - 1; i >= 0; i--) bit7(v[i], first_rst && (i == n - 1));
  endtask

  // ---- CRC16 drivers --------------------------------------------------------
  task automatic bit16(input logic d, input logic r);
    @(negedge clk);
    rst16 = r; en16 = 1'b1; data16 = d;
    @(posedge clk);
    #1;
    rst16 = 1'b0; en16 = 1'b0; data16 = 1'bx;
  endtask

  task automatic idle16(input logic r, input logic d);
    @(negedge clk);
    rst16 = r; en16 = 1'b0; data16 = d;
    @(posedge clk);
    #1;
    rst16 = 1'b0; data16 = 1'bx;
  endtask

  task automatic byte16(input logic [7:0] b, input logic first_rst);
    for (int i = 7; i >= 0; i--) bit16(b[i], first_rst && (i == 7));
  endtask

  task automatic word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit16(w[i], 1'b0);
  endtask

  initial begin
    logic [31:0] m;
    logic [39:0] bad;
    logic [39:0] stream;
    logic [7:0]  sbyte;
    logic [31:0] rnd;
    int          gaps;
    int          flip_pos [3];

    flip_pos = '{0, 17, 39};

    // ---- power-on and plain reset ------------------------------------------
    #1;
    check("power_on_crc7",  32'(crc7),  32'h0);
    check("power_on_crc16", 32'(crc16), 32'h0);
    idle7(1'b1, 1'b1);
    check("reset_crc7", 32'(crc7), 32'h0);

    // ---- CRC7 command frames -----------------------------------------------
    frame7(64'(CMD0), 40, 1'b1);
    check("cmd0_crc7", 32'(crc7), 32'h4A);
    check("cmd0_frame_byte", 32'({crc7, 1'b1}), 32'h95);
    frame7(64'h4A, 7, 1'b0);
    check("cmd0_residue", 32'(crc7), 32'h0);

    frame7(64'(CMD8), 40, 1'b1);
    check("cmd8_crc7", 32'(crc7), 32'h43);
    frame7(64'h43, 7, 1'b0);
    check("cmd8_residue", 32'(crc7), 32'h0);

    frame7(64'(CMD17), 40, 1'b1);
    check("cmd17_crc7", 32'(crc7), 32'h2A);
    frame7(64'h2A, 7, 1'b0);
    check("cmd17_residue", 32'(crc7), 32'h0);

    // ---- single-bit corruption must leave a nonzero residue ----------------
    foreach (flip_pos[k]) begin
      bad = CMD0 ^ (40'd1 << flip_pos[k]);
      frame7(64'(bad), 40, 1'b1);
      frame7(64'h4A, 7, 1'b0);
      check("flip_residue_nonzero", 32'(crc7 != 7'h0), 32'h1);
    end

    // ---- idle gaps with junk on data; register must hold -------------------
    idle7(1'b1, 1'bx);
    check("reset_with_x_data", 32'(crc7), 32'h0);
    m = '0;
    stream = CMD0;
    for (int i = 39; i >= 0; i--) begin
      gaps = int'($urandom_range(0, 3));
      for (int j = 0; j < gaps; j++) begin
        idle7(1'b0, (j % 2 == 1) ? 1'bx : 1'($urandom));
        check("gap_hold_crc7", 32'(crc7), m);
      end
      bit7(stream[i], i == 39);
      m = crc_step((i == 39) ? 32'h0 : m, stream[i], 32'(SD_CRC7_POLY), SD_CRC7_WIDTH);
    end
    check("cmd0_with_gaps", 32'(crc7), 32'h4A);

    // ---- reset in the middle of a frame ------------------------------------
    frame7(64'(CMD8 >> 30), 10, 1'b1);
    idle7(1'b1, 1'bx);
    check("midframe_rst_alone", 32'(crc7), 32'h0);
    frame7(64'(CMD8 >> 25), 15, 1'b0);
    bit7(1'b1, 1'b1);
    check("midframe_rst_en_d1_crc7", 32'(crc7), 32'h09);

    // ---- back-to-back frames, reset only on each first bit -----------------
    frame7(64'(CMD8), 40, 1'b1);
    check("b2b_cmd8", 32'(crc7), 32'h43);
    frame7(64'(CMD17), 40, 1'b1);
    check("b2b_cmd17", 32'(crc7), 32'h2A);
    frame7(64'(CMD0), 40, 1'b1);
    check("b2b_cmd0", 32'(crc7), 32'h4A);

    // ---- CRC16 over "123456789" --------------------------------------------
    for (int k = 0; k < 9; k++) begin
      sbyte = 8'h31 + 8'(k);
      byte16(sbyte, k == 0);
    end
    check("crc16_123456789", 32'(crc16), 32'h31C3);
    word16(16'h31C3);
    check("crc16_residue", 32'(crc16), 32'h0);

    // corrupted message: '4' replaced with '5'
    for (int k = 0; k < 9; k++) begin
      sbyte = (k == 3) ? 8'h35 : 8'h31 + 8'(k);
      byte16(sbyte, k == 0);
    end
    word16(16'h31C3);
    check("crc16_flip_nonzero", 32'(crc16 != 16'h0), 32'h1);

    // ---- CRC16 over a 512-byte block of 0xFF -------------------------------
    for (int k = 0; k < 512; k++) byte16(8'hFF, k == 0);
    check("crc16_512xFF", 32'(crc16), 32'h7FA1);

    // ---- CRC16 reset behaviour and hold ------------------------------------
    bit16(1'b1, 1'b1);
    check("crc16_rst_en_d1", 32'(crc16), 32'h1021);
    idle16(1'b0, 1'bx);
    check("crc16_hold_x", 32'(crc16), 32'h1021);
    idle16(1'b0, 1'b1);
    check("crc16_hold_d1", 32'(crc16), 32'h1021);
    idle16(1'b1, 1'b1);
    check("crc16_rst_alone", 32'(crc16), 32'h0);

    // ---- CRC16 random word against the package reference step --------------
    rnd = $urandom;
    m = '0;
    for (int i = 31; i >= 0; i--) begin
      bit16(rnd[i], i == 31);
      m = crc_step((i == 31) ? 32'h0 : m, rnd[i], 32'(SD_CRC16_POLY), SD_CRC16_WIDTH);
    end
    check("crc16_random_word", 32'(crc16), m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
